hazard_ctrl: RTL



---
 rtl/hazard_ctrl_if.sv | 32 +++
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for hazard_ctrl: ID/EX hazard sources in, stage enables/flushes out.
// master = pipeline datapath, slave = hazard controller.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_IDRsAddr;
  logic [4:0]       IF_IDRtAddr;
  logic             ID_UsesRt;
  logic [4:0]       ID_EXRtAddr;
  logic             ID_EXMem_r;
  logic             ID_EXMdu;
  logic             EX_Branch_taken;
  logic             PC_w;
  logic             IF_ID_w;
  logic             ID_EX_w;
  logic             IF_ID_flush;
  logic             ID_EX_flush;
  logic             EX_MEM_bubble;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output IF_IDRsAddr, IF_IDRtAddr, ID_UsesRt, ID_EXRtAddr, ID_EXMem_r, ID_EXMdu, EX_Branch_taken,
    input  PC_w, IF_ID_w, ID_EX_w, IF_ID_flush, ID_EX_flush, EX_MEM_bubble, mdu_busy, stall_cnt, flush_cnt
  );

  modport slave (
    input  IF_IDRsAddr, IF_IDRtAddr, ID_UsesRt, ID_EXRtAddr, ID_EXMem_r, ID_EXMdu, EX_Branch_taken,
    output PC_w, IF_ID_w, ID_EX_w, IF_ID_flush, ID_EX_flush, EX_MEM_bubble, mdu_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, taken-branch flush and multi-cycle MDU stall sequencing.
// Saturating stall/flush performance counters are built only when HAZ_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst_n,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;

  // The first stall cycle is spent in RUN, so the wait counter covers the remaining MDU_LAT-2.
  localparam bit         MDU_STALL  = (MDU_LAT > 1);
  localparam logic [3:0] MDU_RELOAD = MDU_STALL ? 4'(MDU_LAT - 2) : 4'd0;

  state_t     state_r;
  logic [3:0] cnt_r;

  logic load_use_s;
  logic mdu_start_s;
  logic pc_w_s;
  logic if_id_w_s;
  logic id_ex_w_s;
  logic if_id_flush_s;
  logic id_ex_flush_s;
  logic ex_mem_bubble_s;
  logic mdu_busy_s;

  // Hazard detection terms for the RUN state
  always_comb begin
    load_use_s  = bus.ID_EXMem_r && (bus.ID_EXRtAddr != 5'd0) &&
                  ((bus.ID_EXRtAddr == bus.IF_IDRsAddr) ||
                   (bus.ID_UsesRt && (bus.ID_EXRtAddr == bus.IF_IDRtAddr)));
    mdu_start_s = (state_r == RUN) && !bus.EX_Branch_taken && bus.ID_EXMdu && MDU_STALL;
  end

  // Same-cycle control outputs; while rst_n is low the defaults hold regardless of state
  always_comb begin
    pc_w_s          = 1'b1;
    if_id_w_s       = 1'b1;
    id_ex_w_s       = 1'b1;
    if_id_flush_s   = 1'b0;
    id_ex_flush_s   = 1'b0;
    ex_mem_bubble_s = 1'b0;
    mdu_busy_s      = 1'b0;
    if (!rst_n) begin
      mdu_busy_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (bus.EX_Branch_taken) begin
            if_id_flush_s = 1'b1;
            id_ex_flush_s = 1'b1;
          end else if (mdu_start_s) begin
            pc_w_s          = 1'b0;
            if_id_w_s       = 1'b0;
            id_ex_w_s       = 1'b0;
            ex_mem_bubble_s = 1'b1;
            mdu_busy_s      = 1'b1;
          end else if (load_use_s) begin
            pc_w_s        = 1'b0;
            if_id_w_s     = 1'b0;
            id_ex_flush_s = 1'b1;
          end else begin
            mdu_busy_s = 1'b0;
          end
        end
        MDU_WAIT: begin
          // EX is frozen on the MDU op: branch and load-use inputs are not looked at here
          if (cnt_r != 4'd0) begin
            pc_w_s          = 1'b0;
            if_id_w_s       = 1'b0;
            id_ex_w_s       = 1'b0;
            ex_mem_bubble_s = 1'b1;
            mdu_busy_s      = 1'b1;
          end else begin
            mdu_busy_s = 1'b0;
          end
        end
        default: begin
          mdu_busy_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.PC_w          = pc_w_s;
  assign bus.IF_ID_w       = if_id_w_s;
  assign bus.ID_EX_w       = id_ex_w_s;
  assign bus.IF_ID_flush   = if_id_flush_s;
  assign bus.ID_EX_flush   = id_ex_flush_s;
  assign bus.EX_MEM_bubble = ex_mem_bubble_s;
  assign bus.mdu_busy      = mdu_busy_s;

  // MDU occupancy FSM and countdown; the release cycle returns to RUN without sampling ID_EXMdu
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (mdu_start_s) begin
            state_r <= MDU_WAIT;
            cnt_r   <= MDU_RELOAD;
          end else begin
            state_r <= RUN;
            cnt_r   <= 4'd0;
          end
        end
        MDU_WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating hazard counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_w_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (if_id_flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
